// File: rtl/cardinal_local_port_if.sv
// Link and router-core signal bundle for the cardinal local port.
// The slave modport is the port itself; the master is the NIC/core side.
interface cardinal_local_port_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 net_so;
  logic [63:0]          net_do;
  logic                 net_ro;
  logic                 net_polarity;
  logic                 net_si;
  logic [63:0]          net_dl;
  logic                 net_ri;
  logic                 inj_valid;
  logic [63:0]          inj_data;
  logic                 inj_ready;
  logic                 ej_valid;
  logic [63:0]          ej_data;
  logic                 ej_ready;
  logic [CNT_WIDTH-1:0] inj_cnt;
  logic [CNT_WIDTH-1:0] ej_cnt;

  modport slave (
    input  net_so, net_do, net_ri, inj_ready, ej_valid, ej_data,
    output net_ro, net_polarity, net_si, net_dl, inj_valid, inj_data,
           ej_ready, inj_cnt, ej_cnt
  );

  modport master (
    output net_so, net_do, net_ri, inj_ready, ej_valid, ej_data,
    input  net_ro, net_polarity, net_si, net_dl, inj_valid, inj_data,
           ej_ready, inj_cnt, ej_cnt
  );
endinterface

// File: rtl/cardinal_local_port.sv
// Router-side NIC endpoint: per-VC injection buffers, 2-entry ejection FIFO,
// toggling link polarity and wrap-around packet counters.
module cardinal_local_port #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  cardinal_local_port_if.slave  link
);
  localparam int unsigned DW = 64;

  logic                 pol_q, pol_d;
  logic                 ro_q, ro_d;
  logic [1:0]           full_q, full_d;
  logic [DW-1:0]        buf_q [2];
  logic [DW-1:0]        buf_d [2];
  logic [DW-1:0]        fifo_q [2];
  logic [DW-1:0]        fifo_d [2];
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0] inj_cnt_q, inj_cnt_d;
  logic [CNT_WIDTH-1:0] ej_cnt_q, ej_cnt_d;

  logic inj_valid_c, net_si_c, ej_ready_c;
  logic fill_c, drain_c, push_c, pop_c;

  // Fill always targets VC pol_q and drain VC ~pol_q, so they never collide.
  assign inj_valid_c = full_q[~pol_q];
  assign net_si_c    = (count_q != 2'd0);
  assign ej_ready_c  = (count_q != 2'd2);
  assign fill_c      = link.net_so && ro_q && (link.net_do[63] == pol_q);
  assign drain_c     = inj_valid_c && link.inj_ready;
  assign push_c      = link.ej_valid && ej_ready_c;
  assign pop_c       = net_si_c && link.net_ri;

  always_comb begin
    pol_d     = ~pol_q;
    full_d    = full_q;
    buf_d     = buf_q;
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    inj_cnt_d = inj_cnt_q;
    ej_cnt_d  = ej_cnt_q;

    if (fill_c) begin
      full_d[pol_q] = 1'b1;
      buf_d[pol_q]  = link.net_do;
      inj_cnt_d     = inj_cnt_q + CNT_WIDTH'(1);
    end
    if (drain_c) begin
      full_d[~pol_q] = 1'b0;
    end
    // Ready reflects the buffer that the next polarity will offer to the NIC.
    ro_d = ~full_d[~pol_q];

    if (push_c) begin
      fifo_d[tail_q] = link.ej_data;
      tail_d         = ~tail_q;
    end
    if (pop_c) begin
      head_d   = ~head_q;
      ej_cnt_d = ej_cnt_q + CNT_WIDTH'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pol_q     <= 1'b0;
      ro_q      <= 1'b1;
      full_q    <= 2'b00;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      inj_cnt_q <= '0;
      ej_cnt_q  <= '0;
    end else begin
      pol_q     <= pol_d;
      ro_q      <= ro_d;
      full_q    <= full_d;
      buf_q     <= buf_d;
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      inj_cnt_q <= inj_cnt_d;
      ej_cnt_q  <= ej_cnt_d;
    end
  end

  assign link.net_ro       = ro_q;
  assign link.net_polarity = pol_q;
  assign link.inj_valid    = inj_valid_c;
  assign link.inj_data     = inj_valid_c ? buf_q[~pol_q] : '0;
  assign link.net_si       = net_si_c;
  assign link.net_dl       = net_si_c ? fifo_q[head_q] : '0;
  assign link.ej_ready     = ej_ready_c;
  assign link.inj_cnt      = inj_cnt_q;
  assign link.ej_cnt       = ej_cnt_q;
endmodule

// File: doc/cardinal_local_port.md
# cardinal_local_port

Router-side endpoint of the NIC link: the other end of the net_so/net_ro/net_polarity/net_do and net_si/net_ri/net_dl handshakes the NIC drives. Accepts injected packets from the NIC into one buffer per virtual channel (VC = bit 63), hands them to the router core, and delivers router-core packets to the NIC through a 2-entry ejection FIFO. Owns the link polarity, which toggles every cycle. Counts packets in each direction.

## Interface
- CNT_WIDTH, 16, width of the packet counters (wrap-around)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- net_so  in  1  NIC send request
- net_do  in  64  NIC packet; bit 63 = VC
- net_ro  out  1  port ready for the VC equal to net_polarity (registered)
- net_polarity  out  1  current link polarity (registered, toggles every cycle)
- net_si  out  1  packet valid toward NIC
- net_dl  out  64  packet toward NIC
- net_ri  in  1  NIC ready to receive
- inj_valid  out  1  injected packet available to the router core
- inj_data  out  64  injected packet
- inj_ready  in  1  router core accepts inj_data
- ej_valid  in  1  router core presents a packet for the NIC
- ej_data  in  64  packet for the NIC
- ej_ready  out  1  ejection FIFO can accept
- inj_cnt  out  CNT_WIDTH  packets accepted from the NIC
- ej_cnt  out  CNT_WIDTH  packets delivered to the NIC

## Operation
- Reset (asynchronous): net_polarity=0, net_ro=1, both VC buffers empty, inj_valid=0, inj_data=0, ejection FIFO empty, net_si=0, net_dl=0, ej_ready=1, both counters 0.
- Polarity: net_polarity <= ~net_polarity on every non-reset edge.
- Injection capture: at an edge with net_so=1, net_ro=1, and net_do[63]==net_polarity, net_do is written to vc_buf[net_polarity], which becomes full, and inj_cnt increments. If net_do[63]!=net_polarity or net_ro=0, the packet is ignored (the NIC retries).
- net_ro: registered. Each edge loads ~full_next[~net_polarity], i.e. the emptiness of the buffer selected by the next polarity after this edge's fill and drain.
- Injection drain: inj_valid = full[~net_polarity]; inj_data = vc_buf[~net_polarity] (0 when not valid). On an edge with inj_valid && inj_ready, that buffer empties. A buffer is never filled and drained on the same edge, because fill targets VC net_polarity and drain targets VC ~net_polarity.
- Ejection FIFO: 2 entries with head and tail pointers and a count of 0..2.
  - ej_ready = (count<2); there is no push-while-full, even if a pop occurs that cycle.
  - Push on ej_valid && ej_ready.
  - net_si = (count!=0); net_dl = head entry (0 when empty).
  - Pop on net_si && net_ri; ej_cnt increments on each pop.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo 2.
- Both counters wrap from all-ones to 0.
- Reset asserted mid-operation drops all buffered packets and returns every output to its reset value immediately.

## Timing
- net_polarity after reset release: 0, then 1, 0, … on successive edges.
- NIC to core: a packet captured at edge N appears on inj_valid/inj_data after edge N. The earliest it can drain is at the next edge (N+1), where the polarity has flipped and the buffer becomes the drain target. Minimum latency is 1 cycle. If the core stalls, the buffer holds and net_ro stays 0 on that VC's polarity.
- Per-VC injection throughput: one packet every 2 cycles when the core never stalls.
- Core to NIC: a packet pushed at edge N is on net_si/net_dl after edge N (1-cycle latency). Throughput is 1 per cycle when net_ri stays high.
- net_dl and net_si are stable while net_si=1 and net_ri=0.

## Test plan
- Reset check: pulse reset mid-traffic with no clock edge → net_ro=1, net_si=0, net_polarity=0, inj_valid=0, ej_ready=1, counters 0, all asynchronously.
- Injection, matching VC: hold net_so=1 with net_do=64'h8000_0000_0000_00AA. Capture occurs only at an edge where net_polarity=1. One cycle later inj_valid=1 with that data; with inj_ready=1 it drains at the following edge; inj_cnt=1.
- Core stall: inject VC0 packet 64'h11, hold inj_ready=0 → net_ro reads 0 in every polarity-0 cycle. A second VC0 offer of 64'h22 is not captured. Release inj_ready → 64'h11 drains, net_ro returns to 1, and 64'h22 is then captured.
- Ejection FIFO full: net_ri=0, push 64'hA1 then 64'hA2 → ej_ready=0 with count 2, and a third ej_valid is refused. Raise net_ri → NIC receives A1 then A2 on consecutive edges; ej_cnt=2.
- Simultaneous push and pop at count 1: push 64'hB2 while popping 64'hB1 → count stays 1 and net_dl=64'hB2 next cycle.
- Counter wrap: with CNT_WIDTH=4, inject 16 packets → inj_cnt returns to 0.
